l3_repl_ctrl: RTL and testbench
===============================

Name: l3_repl_ctrl

Overview:
- Sequencer and arbiter for the L3 per-set pseudo-LRU replacement state array, which is an external single-port SRAM, one word of WAYS-1 bits per set.
- Shares the array between NUM_REQ requesters (tag pipelines and fill engine) through round-robin arbitration.
- Runs a read-modify-write per request:
  - touch: mark a hit way most-recently-used.
  - alloc: select a victim way, mark it MRU, return it.
- Performs an initial clearing sweep of the array after reset.

Parameters:
- WAYS, 16, associativity; power of 2, 2..32.
- SETS, 4096, number of sets; power of 2.
- IDX_W, 12, set-index width, equal to log2(SETS).
- NUM_REQ, 4, number of requesters, 2..8.
- ID_W, 2, requester-id width, equal to log2(NUM_REQ).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes when valid and ready are both high.
- req_alloc  in  NUM_REQ  per requester: 1 = alloc, 0 = touch.
- req_index  in  NUM_REQ*IDX_W  per-requester set index; requester i uses slice [i*IDX_W +: IDX_W].
- req_way  in  NUM_REQ*WAYS  per-requester one-hot hit way (touch only).
- rsp_valid  out  1  one-cycle pulse returning an alloc result.
- rsp_id  out  ID_W  id of the requester that owns the response.
- rsp_way  out  WAYS  one-hot victim way.
- plru_en  out  1  array access enable.
- plru_we  out  1  array write enable (qualified by plru_en).
- plru_addr  out  IDX_W  array address.
- plru_wdata  out  WAYS-1  array write data.
- plru_rdata  in  WAYS-1  array read data, valid the cycle after a read.
- init_done  out  1  high once the clearing sweep has completed.

Behaviour:
- Tree encoding:
  - Node n has children 2n+1 and 2n+2; way w is leaf node WAYS-1+w.
  - Node bit 0 means the victim lies in the left subtree; 1 means the right subtree.
  - Victim: walk from the root following the bits.
  - Access to way w: every node on w's path is set to point away from w (bit = 1 if w is in the left subtree, else 0). Bits off the path are unchanged.
- Reset values: state INIT, sweep counter 0, round-robin pointer 0, all outputs 0.
- Reset mid-operation: the in-flight operation is dropped; no response and no write are issued.
- FSM states: INIT, IDLE, UPD.
- INIT state:
  - Each cycle: plru_en=1, plru_we=1, plru_addr=counter, plru_wdata=0; counter increments.
  - After the write to SETS-1: move to IDLE and set init_done=1, which stays high until rst.
  - req_ready=0 throughout INIT.
- IDLE state:
  - If any req_valid is set, grant the first valid requester searching from ptr+1 upward, wrapping modulo NUM_REQ.
  - In the same cycle: drive req_ready of the winner only, and plru_en=1, plru_we=0, plru_addr=req_index[winner].
  - Capture id, index, alloc and way into registers; set ptr=winner; go to UPD.
  - With no valid request: all strobes 0 and ptr is held.
- UPD state (one cycle):
  - plru_rdata is valid this cycle.
  - Alloc:
    - victim = tree walk.
    - Write the updated tree to the same index.
    - Drive rsp_valid=1, rsp_id=captured id, rsp_way=victim one-hot.
  - Touch:
    - Uses the lowest set bit of the captured way.
    - If the captured way is all-zero: no write and no response.
  - Return to IDLE.
- Latency and throughput:
  - Grant-to-response is 1 cycle; rsp_valid is asserted in the cycle after the handshake.
  - Throughput is one operation per 2 cycles.
  - The array must return write-cycle data on a read issued in the next cycle, so back-to-back operations on the same set need no forwarding.
- Request stability: requesters hold valid and payload until ready. A requester may drop valid before being granted.
- Touch operations produce no response; the requester considers a touch complete at its handshake.
- rsp_way is held at 0 when rsp_valid is 0.

Optional Feature:
- Macro: L3_REPL_WAY_LOCK_EN.
- Defined:
  - Adds input port cfg_way_lock[WAYS-1:0], a static mask of locked ways.
  - If the tree victim is locked, the victim becomes the lowest-index unlocked way.
  - If all ways are locked, the mask is ignored.
  - The tree is updated for the way actually returned.
  - Touch operations are unaffected.
- Not defined: the port is absent and the victim is always the tree walk.

Test Plan:
- Init sweep: deassert rst -> exactly 4096 writes with wdata=0 at addresses 0..4095 in consecutive cycles; init_done rises the cycle after address 4095; no req_ready during the sweep.
- Alloc on a fresh set: req0 alloc, index 0x005, rdata=0 -> rsp_way=0x0001, rsp_id=0, write to 0x005 with nodes 0, 1, 3, 7 set to 1; a second alloc on 0x005 -> rsp_way=0x0100.
- Touch: req1 touch, index 0x3FF, way 0x8000, rdata=0 -> write with nodes 0, 2, 6, 14 set to 0 (wdata=0), rsp_valid stays 0; the same request with way 0x0000 -> no write.
- Round-robin: all 4 requesters valid continuously starting from ptr=0 -> grants in order 1, 2, 3, 0, 1, ... with one grant every 2 cycles and no starvation.
- Reset during UPD: assert rst in the UPD cycle -> no rsp_valid, no write, and the FSM re-enters INIT with the counter at 0.
- L3_REPL_WAY_LOCK_EN: cfg_way_lock=0x0001, alloc with rdata=0 -> rsp_way=0x0002; with cfg_way_lock=0xFFFF -> rsp_way=0x0001.

Source files
------------

// File: rtl/l3_repl_ctrl.sv
// L3 tree-PLRU replacement sequencer: round-robin arbiter, read-modify-write of the
// per-set state array and post-reset clearing sweep. Optional way locking: L3_REPL_WAY_LOCK_EN.
module l3_repl_ctrl #(
    parameter int WAYS    = 16,
    parameter int SETS    = 4096,
    parameter int IDX_W   = 12,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef L3_REPL_WAY_LOCK_EN
    input  logic [WAYS-1:0]          cfg_way_lock,
`endif
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_alloc,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    input  logic [NUM_REQ*WAYS-1:0]  req_way,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WAYS-1:0]          rsp_way,
    output logic                     plru_en,
    output logic                     plru_we,
    output logic [IDX_W-1:0]         plru_addr,
    output logic [WAYS-2:0]          plru_wdata,
    input  logic [WAYS-2:0]          plru_rdata,
    output logic                     init_done
);
    localparam int LVLS = $clog2(WAYS);
    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;
    localparam logic [IDX_W-1:0]   LAST_SET = IDX_W'(SETS - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [WAYS-1:0]    WAY_ONE  = {{(WAYS-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Nodes of depth d start at 2^d-1; the victim prefix chosen so far selects the node.
    function automatic logic [LVLS-1:0] tree_victim(input logic [WAYS-2:0] tree);
        logic [WAYS-1:0] tp;
        logic [LVLS-1:0] v;
        logic [LVLS-1:0] node;
        tp = {1'b0, tree};
        v  = {LVLS{1'b0}};
        for (int d = 0; d < LVLS; d++) begin
            node = LVLS'((1 << d) - 1) + v;
            v    = (v << 1) | LVLS'(tp[node]);
        end
        return v;
    endfunction

    function automatic logic [WAYS-2:0] tree_touch(input logic [WAYS-2:0] tree,
                                                   input logic [LVLS-1:0] way);
        logic [WAYS-1:0] tp;
        logic [LVLS-1:0] node;
        tp = {1'b0, tree};
        for (int d = 0; d < LVLS; d++) begin
            node     = LVLS'((1 << d) - 1) + LVLS'(way >> (LVLS - d));
            tp[node] = ~way[LVLS-1-d];
        end
        return tp[WAYS-2:0];
    endfunction

    function automatic logic [LVLS-1:0] lowest_set(input logic [WAYS-1:0] vec);
        logic [LVLS-1:0] idx;
        idx = {LVLS{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            idx = vec[w] ? LVLS'(w) : idx;
        end
        return idx;
    endfunction

    logic [1:0]         state_r;
    logic [IDX_W-1:0]   cnt_r;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [IDX_W-1:0]   idx_r;
    logic               alloc_r;
    logic [WAYS-1:0]    way_r;
    logic               init_done_r;

    logic               gnt_hit_s;
    logic [ID_W-1:0]    gnt_id_s;
    logic [IDX_W-1:0]   gnt_index_s;
    logic [WAYS-1:0]    gnt_way_s;
    logic [LVLS-1:0]    tree_vic_s;
    logic [LVLS-1:0]    vic_idx_s;
    logic [LVLS-1:0]    upd_idx_s;
    logic [WAYS-2:0]    new_tree_s;

    // Round-robin pick: the first valid requester after the previous winner.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_hit_s = 1'b0;
        gnt_id_s  = {ID_W{1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand      = (int'(ptr_r) + k) % NUM_REQ;
            gnt_hit_s = gnt_hit_s | req_valid[cand];
            gnt_id_s  = req_valid[cand] ? ID_W'(cand) : gnt_id_s;
        end
        gnt_index_s = req_index[gnt_id_s*IDX_W +: IDX_W];
        gnt_way_s   = req_way[gnt_id_s*WAYS +: WAYS];
    end

    // Victim selection and updated tree for the captured request.
    always_comb begin
        tree_vic_s = tree_victim(plru_rdata);
`ifdef L3_REPL_WAY_LOCK_EN
        vic_idx_s  = (cfg_way_lock[tree_vic_s] && (cfg_way_lock != {WAYS{1'b1}}))
                     ? lowest_set(~cfg_way_lock) : tree_vic_s;
`else
        vic_idx_s  = tree_vic_s;
`endif
        upd_idx_s  = alloc_r ? vic_idx_s : lowest_set(way_r);
        new_tree_s = tree_touch(plru_rdata, upd_idx_s);
    end

    // Strobes are suppressed while rst is high so a reset drops the in-flight operation.
    always_comb begin
        req_ready  = {NUM_REQ{1'b0}};
        rsp_valid  = 1'b0;
        rsp_id     = {ID_W{1'b0}};
        rsp_way    = {WAYS{1'b0}};
        plru_en    = 1'b0;
        plru_we    = 1'b0;
        plru_addr  = {IDX_W{1'b0}};
        plru_wdata = {(WAYS-1){1'b0}};
        if (!rst) begin
            case (state_r)
                S_INIT: begin
                    plru_en   = 1'b1;
                    plru_we   = 1'b1;
                    plru_addr = cnt_r;
                end
                S_IDLE: begin
                    if (gnt_hit_s) begin
                        req_ready = REQ_ONE << gnt_id_s;
                        plru_en   = 1'b1;
                        plru_addr = gnt_index_s;
                    end else begin
                        req_ready = {NUM_REQ{1'b0}};
                    end
                end
                S_UPD: begin
                    plru_addr = idx_r;
                    if (alloc_r || (|way_r)) begin
                        plru_en    = 1'b1;
                        plru_we    = 1'b1;
                        plru_wdata = new_tree_s;
                    end else begin
                        plru_en    = 1'b0;
                    end
                    if (alloc_r) begin
                        rsp_valid = 1'b1;
                        rsp_id    = id_r;
                        rsp_way   = WAY_ONE << vic_idx_s;
                    end else begin
                        rsp_valid = 1'b0;
                    end
                end
                default: begin
                    plru_en = 1'b0;
                end
            endcase
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Sequencer state, sweep counter, arbitration pointer and captured request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_INIT;
            cnt_r       <= {IDX_W{1'b0}};
            ptr_r       <= {ID_W{1'b0}};
            id_r        <= {ID_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            alloc_r     <= 1'b0;
            way_r       <= {WAYS{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                S_INIT: begin
                    cnt_r <= cnt_r + IDX_ONE;
                    if (cnt_r == LAST_SET) begin
                        state_r     <= S_IDLE;
                        init_done_r <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (gnt_hit_s) begin
                        id_r    <= gnt_id_s;
                        idx_r   <= gnt_index_s;
                        alloc_r <= req_alloc[gnt_id_s];
                        way_r   <= gnt_way_s;
                        ptr_r   <= gnt_id_s;
                        state_r <= S_UPD;
                    end
                end
                S_UPD: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_INIT;
                end
            endcase
        end
    end

    assign init_done = init_done_r;

endmodule

// File: tb/tb_l3_repl_ctrl.sv
// Bench for l3_repl_ctrl: SRAM model, spec-level PLRU reference model, scoreboard
// monitor, directed scenarios and randomized multi-requester traffic.
`timescale 1ns/1ps
module tb_l3_repl_ctrl;
    localparam int WAYS = 16, SETS = 4096, IDX_W = 12, NUM_REQ = 4, ID_W = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid, req_ready, req_alloc;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic [NUM_REQ*WAYS-1:0]  req_way;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [WAYS-1:0]          rsp_way;
    logic                     plru_en, plru_we;
    logic [IDX_W-1:0]         plru_addr;
    logic [WAYS-2:0]          plru_wdata, plru_rdata;
    logic                     init_done;
`ifdef L3_REPL_WAY_LOCK_EN
    logic [WAYS-1:0]          lock_v = '0;
`endif

    always #5 clk = ~clk;

    l3_repl_ctrl #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
`ifdef L3_REPL_WAY_LOCK_EN
        .cfg_way_lock(lock_v),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_alloc(req_alloc),
        .req_index(req_index), .req_way(req_way),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_way(rsp_way),
        .plru_en(plru_en), .plru_we(plru_we), .plru_addr(plru_addr),
        .plru_wdata(plru_wdata), .plru_rdata(plru_rdata), .init_done(init_done)
    );

    // Single-port array: read data appears the cycle after the read.
    logic [WAYS-2:0] mem [SETS];
    always @(posedge clk) begin
        if (plru_en && plru_we) mem[plru_addr] <= plru_wdata;
        else if (plru_en)       plru_rdata <= mem[plru_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference tree, straight from the node rules: children of n are 2n+1 and 2n+2.
    function automatic int m_victim(input logic [WAYS-2:0] t);
        int n;
        n = 0;
        while (n < WAYS - 1) n = 2 * n + 1 + (t[n] ? 1 : 0);
        return n - (WAYS - 1);
    endfunction

    function automatic logic [WAYS-2:0] m_access(input logic [WAYS-2:0] t, input int w);
        int n, p;
        n = WAYS - 1 + w;
        while (n > 0) begin
            p = (n - 1) / 2;
            t[p] = (n == 2 * p + 1);
            n = p;
        end
        return t;
    endfunction

    function automatic int m_lowest(input logic [WAYS-1:0] v);
        for (int i = 0; i < WAYS; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct { int due; int id; logic [WAYS-1:0] way; } rsp_t;
    typedef struct { int due; logic [IDX_W-1:0] addr; logic [WAYS-2:0] data; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    logic [WAYS-2:0] ref_tree [SETS];
    bit   run_en = 1'b0;
    bit   busy_m = 1'b0;
    int   ptr_m  = 0;

    // Reference model: predicts grants and pushes expected writes/responses at each handshake.
    initial forever begin
        int win, c, v, h;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [IDX_W-1:0]   idx;
        logic [WAYS-2:0]    t;
        rsp_t re;
        wr_t  we;
        @(negedge clk);
        if (run_en) begin
            win = -1;
            if (!busy_m) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (ptr_m + k) % NUM_REQ;
                    if (win < 0 && req_valid[c]) win = c;
                end
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            check("grant", req_ready, exp_rdy);
            busy_m = 1'b0;
            if (win >= 0) begin
                idx = req_index[win*IDX_W +: IDX_W];
                check("read_strobe", {plru_en, plru_we, plru_addr}, {1'b1, 1'b0, idx});
                t = ref_tree[idx];
                if (req_alloc[win]) begin
                    v = m_victim(t);
`ifdef L3_REPL_WAY_LOCK_EN
                    if (lock_v[v] && lock_v != {WAYS{1'b1}}) v = m_lowest(~lock_v);
`endif
                    ref_tree[idx] = m_access(t, v);
                    re.due = cyc + 1; re.id = win; re.way = '0; re.way[v] = 1'b1;
                    rsp_q.push_back(re);
                    we.due = cyc + 1; we.addr = idx; we.data = ref_tree[idx];
                    wr_q.push_back(we);
                end else begin
                    h = m_lowest(req_way[win*WAYS +: WAYS]);
                    if (h >= 0) begin
                        ref_tree[idx] = m_access(t, h);
                        we.due = cyc + 1; we.addr = idx; we.data = ref_tree[idx];
                        wr_q.push_back(we);
                    end
                end
                busy_m = 1'b1;
                ptr_m  = win;
            end
        end
    end

    // Monitor: compares DUT responses and array writes against the scoreboard queues.
    initial forever begin
        rsp_t re;
        wr_t  we;
        @(negedge clk);
        if (run_en) begin
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                re = rsp_q.pop_front();
                check("rsp_valid", rsp_valid, 1'b1);
                check("rsp_id", rsp_id, re.id);
                check("rsp_way", rsp_way, re.way);
            end else begin
                check("rsp_quiet", {rsp_valid, rsp_way}, '0);
            end
            if (wr_q.size() > 0 && wr_q[0].due <= cyc) begin
                we = wr_q.pop_front();
                check("wr_strobe", {plru_en, plru_we}, 2'b11);
                check("wr_addr", plru_addr, we.addr);
                check("wr_data", plru_wdata, we.data);
            end else begin
                check("no_write", plru_en & plru_we, 1'b0);
            end
        end
    end

    task automatic sweep_check();
        int bad;
        bad = 0;
        for (int i = 0; i < SETS; i++) begin
            @(negedge clk);
            if (!(plru_en === 1'b1 && plru_we === 1'b1 && plru_addr === IDX_W'(i) &&
                  plru_wdata === '0 && req_ready === '0 && init_done === 1'b0)) begin
                bad++;
                if (bad < 4) $display("sweep cycle %0d: en=%b we=%b addr=0x%0h rdy=%b", i,
                                      plru_en, plru_we, plru_addr, req_ready);
            end
        end
        check("sweep_bad_cycles", bad, 0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("init_done", init_done, 1'b1);
        check("post_sweep_quiet", {plru_en, req_ready}, '0);
    endtask

    task automatic model_start();
        for (int s = 0; s < SETS; s++) ref_tree[s] = '0;
        rsp_q.delete();
        wr_q.delete();
        ptr_m  = 0;
        busy_m = 1'b0;
        run_en = 1'b1;
    endtask

    task automatic issue(input int id, input bit alloc, input logic [IDX_W-1:0] idx,
                         input logic [WAYS-1:0] way);
        int t;
        t = 0;
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        req_alloc[id] = alloc;
        req_index[id*IDX_W +: IDX_W] = idx;
        req_way[id*WAYS +: WAYS] = way;
        @(negedge clk);
        while (!req_ready[id] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("grant_wait", req_ready[id], 1'b1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    initial begin
        logic [NUM_REQ-1:0] g, exp_rr;
        rst = 1'b1; req_valid = '0; req_alloc = '0; req_index = '0; req_way = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {req_ready, rsp_valid, rsp_way, plru_en, plru_we, init_done}, '0);

        // Requests held during the sweep must not be granted.
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '1;
        sweep_check();
        model_start();

        // Round-robin with every requester valid (touch, way 0: no writes).
        @(posedge clk); #1;
        req_valid = '1;
        for (int gi = 0; gi < 12; gi++) begin
            @(negedge clk);
            exp_rr = '0;
            if (gi % 2 == 0) exp_rr[(gi / 2 + 1) % NUM_REQ] = 1'b1;
            check("rr_order", req_ready, exp_rr);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(negedge clk);

        issue(0, 1'b1, 12'h005, 16'h0000);
        @(negedge clk);
        check("alloc1_way", rsp_way, 16'h0001);
        check("alloc1_id", rsp_id, 2'd0);
        check("alloc1_wr", {plru_we, plru_addr, plru_wdata}, {1'b1, 12'h005, 15'h008B});
        issue(0, 1'b1, 12'h005, 16'h0000);
        @(negedge clk);
        check("alloc2_way", rsp_way, 16'h0100);
        check("alloc2_wdata", plru_wdata, 15'h08AE);
        issue(1, 1'b0, 12'h3FF, 16'h8000);
        @(negedge clk);
        check("touch_rsp", rsp_valid, 1'b0);
        check("touch_wr", {plru_en, plru_we, plru_addr, plru_wdata}, {2'b11, 12'h3FF, 15'h0000});
        issue(1, 1'b0, 12'h3FF, 16'h0000);
        @(negedge clk);
        check("touch_zero_nowr", {plru_en, plru_we, rsp_valid}, 3'b000);
`ifdef L3_REPL_WAY_LOCK_EN
        lock_v = 16'h0001;
        issue(2, 1'b1, 12'h010, 16'h0000);
        @(negedge clk);
        check("lock_one_way", rsp_way, 16'h0002);
        lock_v = 16'hFFFF;
        issue(3, 1'b1, 12'h011, 16'h0000);
        @(negedge clk);
        check("lock_all_way", rsp_way, 16'h0001);
        @(posedge clk); #1;
        lock_v = 16'h0000;
`endif

        // Randomized traffic; requesters may withdraw before being granted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (g[i]) req_valid[i] = 1'b0;
                else if (req_valid[i] && $urandom_range(7) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_alloc[i] = 1'($urandom_range(1));
                    req_index[i*IDX_W +: IDX_W] = ($urandom_range(3) == 0) ?
                        IDX_W'($urandom_range(SETS - 1)) : IDX_W'($urandom_range(7));
                    case ($urandom_range(3))
                        0:       req_way[i*WAYS +: WAYS] = '0;
                        1:       req_way[i*WAYS +: WAYS] = WAYS'(1) << $urandom_range(WAYS - 1);
                        default: req_way[i*WAYS +: WAYS] = WAYS'($urandom);
                    endcase
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", rsp_q.size() + wr_q.size(), 0);

        // Reset in the UPD cycle: the operation is dropped and the sweep restarts at 0.
        run_en = 1'b0;
        issue(2, 1'b1, 12'h040, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        check("rst_upd_rsp", {rsp_valid, rsp_way}, '0);
        check("rst_upd_nowr", {plru_en, plru_we}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        sweep_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
